// File: rtl/pio_irq_event_master.sv
`timescale 1ns/1ps
// pio_irq_event_master
// Avalon-MM initiator that services a 16-bit interrupt-capable input PIO.
// On irq it reads the PIO data register, turns the armed bits that fired into
// an event, and disarms those bits in the PIO mask so that a held level cannot
// retrigger. Events are queued in a small first-word-fall-through FIFO and
// presented on a valid/ready stream. Consumers re-arm bits with a pulse.
//
// Optional feature: define PIO_EVT_TIMESTAMP_EN to stamp each event with a
// 16-bit free-running cycle count in ev_data[31:16]. When it is undefined,
// no counter exists and ev_data[31:16] is always zero.
module pio_irq_event_master #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] ARM_INIT = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [1:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write_n,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        irq_in,
   input  logic        rearm_valid,
   input  logic [15:0] rearm_mask,
   output logic        ev_valid,
   input  logic        ev_ready,
   output logic [31:0] ev_data,
   output logic [7:0]  ovf_count,
   output logic [15:0] armed
);

   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      WRMASK = 2'd0,
      IDLE   = 2'd1,
      RDADDR = 2'd2,
      RDCAP  = 2'd3
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic          started_r;
   logic [15:0]   armed_r;
   logic [15:0]   armed_s;
   logic [15:0]   pending_r;
   logic [15:0]   pending_s;
   logic [15:0]   fired_s;
   logic [15:0]   rearm_bits_s;
   logic          push_s;
   logic [15:0]   stamp_s;

   logic [31:0]   mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic [AW:0]   count_s;
   logic          full_s;
   logic          pop_s;
   logic          accept_s;
   logic          drop_s;
   logic          ev_valid_r;
   logic [7:0]    ovf_r;

   // Upper half of the PIO read data carries nothing of interest.
   logic          unused_s;
   assign unused_s = ^avm_readdata[31:16];

`ifdef PIO_EVT_TIMESTAMP_EN
   logic [15:0] ts_r;

   // Free-running cycle counter used to stamp events; wraps naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ts_r <= 16'h0000;
      end else begin
         ts_r <= ts_r + 16'h0001;
      end
   end

   assign stamp_s = ts_r;
`else
   assign stamp_s = 16'h0000;
`endif

   // State register plus a flag that holds the FSM in WRMASK for the first cycle after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= WRMASK;
         started_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         started_r <= 1'b1;
      end
   end

   // Next-state decode; a capture with armed bits set produces a push.
   always_comb begin
      state_s = state_r;
      push_s  = 1'b0;
      fired_s = avm_readdata[15:0] & armed_r;
      if (!started_r) begin
         state_s = WRMASK;
      end else begin
         case (state_r)
            WRMASK: begin
               state_s = IDLE;
            end
            IDLE: begin
               if (irq_in) begin
                  state_s = RDADDR;
               end else if (pending_r != 16'h0000) begin
                  state_s = WRMASK;
               end else begin
                  state_s = IDLE;
               end
            end
            RDADDR: begin
               state_s = RDCAP;
            end
            RDCAP: begin
               if (fired_s != 16'h0000) begin
                  push_s  = 1'b1;
                  state_s = WRMASK;
               end else if (pending_r != 16'h0000) begin
                  state_s = WRMASK;
               end else begin
                  state_s = IDLE;
               end
            end
            default: begin
               state_s = WRMASK;
            end
         endcase
      end
   end

   // Armed/pending update: disarm fired bits (a same-cycle re-arm wins),
   // fold pending into armed on entry to WRMASK, keep a coincident re-arm pending.
   always_comb begin
      armed_s   = armed_r;
      pending_s = pending_r;
      if (rearm_valid) begin
         rearm_bits_s = rearm_mask;
      end else begin
         rearm_bits_s = 16'h0000;
      end
      if (push_s) begin
         armed_s = armed_r & ~(fired_s & ~rearm_bits_s);
      end else begin
         armed_s = armed_r;
      end
      if (state_s == WRMASK) begin
         armed_s   = armed_s | pending_r;
         pending_s = rearm_bits_s;
      end else begin
         pending_s = pending_r | rearm_bits_s;
      end
   end

   // Armed mask and pending re-arm registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed_r   <= ARM_INIT;
         pending_r <= 16'h0000;
      end else begin
         armed_r   <= armed_s;
         pending_r <= pending_s;
      end
   end

   // Bus outputs registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_address    <= 2'd0;
         avm_writedata  <= 32'h0000_0000;
      end else begin
         case (state_s)
            WRMASK: begin
               avm_chipselect <= 1'b1;
               avm_write_n    <= 1'b0;
               avm_address    <= 2'd2;
               avm_writedata  <= {16'h0000, armed_s};
            end
            RDADDR: begin
               avm_chipselect <= 1'b1;
               avm_write_n    <= 1'b1;
               avm_address    <= 2'd0;
               avm_writedata  <= 32'h0000_0000;
            end
            IDLE, RDCAP: begin
               avm_chipselect <= 1'b0;
               avm_write_n    <= 1'b1;
               avm_address    <= 2'd0;
               avm_writedata  <= 32'h0000_0000;
            end
            default: begin
               avm_chipselect <= 1'b0;
               avm_write_n    <= 1'b1;
               avm_address    <= 2'd0;
               avm_writedata  <= 32'h0000_0000;
            end
         endcase
      end
   end

   // FIFO control: a push on full is still accepted when the head leaves in the same cycle.
   always_comb begin
      full_s   = (count_r == (AW+1)'(DEPTH));
      pop_s    = ev_ready && (count_r != '0);
      accept_s = push_s && (!full_s || pop_s);
      drop_s   = push_s && full_s && !pop_s;
      case ({accept_s, pop_s})
         2'b10:   count_s = count_r + (AW+1)'(1);
         2'b01:   count_s = count_r - (AW+1)'(1);
         default: count_s = count_r;
      endcase
   end

   // FIFO storage, pointers, occupancy and valid flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'h0000_0000;
         end
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         ev_valid_r <= 1'b0;
      end else begin
         if (accept_s) begin
            mem_r[wr_ptr_r] <= {stamp_s, fired_s};
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         count_r    <= count_s;
         ev_valid_r <= (count_s != '0);
      end
   end

   // Saturating count of events lost to a full FIFO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_r <= 8'h00;
      end else if (drop_s && (ovf_r != 8'hFF)) begin
         ovf_r <= ovf_r + 8'h01;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ev_valid  = ev_valid_r;
   assign ev_data   = mem_r[rd_ptr_r];
   assign ovf_count = ovf_r;
   assign armed     = armed_r;

endmodule

// File: tb/tb_pio_irq_event_master.sv
`timescale 1ns/1ps
// Directed testbench for pio_irq_event_master with a small model of the
// interrupt-capable input PIO (mask register, registered read data, level irq).
module tb_pio_irq_event_master;

   localparam int          DEPTH = 4;
   localparam logic [15:0] ARM   = 16'h00FF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        irq_in;
   logic        rearm_valid;
   logic [15:0] rearm_mask;
   logic        ev_valid;
   logic        ev_ready;
   logic [31:0] ev_data;
   logic [7:0]  ovf_count;
   logic [15:0] armed;

   logic [15:0] in_port;
   logic [15:0] pio_mask;
   int          wr_count;
   int          checks;
   int          errors;

   pio_irq_event_master #(.DEPTH(DEPTH), .ARM_INIT(ARM)) dut (
      .clk(clk), .reset_n(reset_n),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .irq_in(irq_in),
      .rearm_valid(rearm_valid), .rearm_mask(rearm_mask),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
      .ovf_count(ovf_count), .armed(armed)
   );

   always #5 clk = ~clk;

   // PIO slave model: mask register at word 2, registered read data.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pio_mask     <= 16'h0000;
         avm_readdata <= 32'h0;
      end else begin
         if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
            pio_mask <= avm_writedata[15:0];
         if (avm_chipselect && avm_write_n)
            avm_readdata <= (avm_address == 2'd0) ? {16'h0, in_port} :
                            (avm_address == 2'd2) ? {16'h0, pio_mask} : 32'h0;
      end
   end

   assign irq_in = |(in_port & pio_mask);

   // Count completed bus write cycles.
   always @(posedge clk) begin
      if (reset_n && avm_chipselect && !avm_write_n)
         wr_count <= wr_count + 1;
   end

   task automatic test_reset;
      reset_n = 1'b0; in_port = 16'h0; rearm_valid = 1'b0; rearm_mask = 16'h0; ev_ready = 1'b0;
      wr_count = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({avm_chipselect, avm_write_n, avm_address} !== 4'b0100) begin
         errors++; $display("FAIL reset_bus: cs/wn/addr=%b required 0100", {avm_chipselect, avm_write_n, avm_address});
      end
      checks++;
      if (avm_writedata !== 32'h0) begin
         errors++; $display("FAIL reset_wdata: got %h required 0", avm_writedata);
      end
      checks++;
      if (ev_valid !== 1'b0 || ev_data !== 32'h0 || ovf_count !== 8'h0) begin
         errors++; $display("FAIL reset_ev: valid=%b data=%h ovf=%0d required 0/0/0", ev_valid, ev_data, ovf_count);
      end
      checks++;
      if (armed !== ARM) begin
         errors++; $display("FAIL reset_armed: got %h required %h", armed, ARM);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (!(avm_chipselect === 1'b1 && avm_write_n === 1'b0 && avm_address === 2'd2 && avm_writedata === 32'h000000FF)) begin
         errors++; $display("FAIL init_write: cs=%b wn=%b addr=%0d wd=%h required 1 0 2 000000ff", avm_chipselect, avm_write_n, avm_address, avm_writedata);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (wr_count !== 1 || avm_chipselect !== 1'b0) begin
         errors++; $display("FAIL init_once: writes=%0d cs=%b required 1 and 0", wr_count, avm_chipselect);
      end
      checks++;
      if (ev_valid !== 1'b0 || pio_mask !== 16'h00FF) begin
         errors++; $display("FAIL init_idle: ev_valid=%b pio_mask=%h required 0 and 00ff", ev_valid, pio_mask);
      end
   endtask

   task automatic test_single_event;
      in_port = 16'h0005;                       // cycle T
      @(negedge clk);                           // T+1
      checks++;
      if (!(avm_chipselect === 1'b1 && avm_write_n === 1'b1 && avm_address === 2'd0)) begin
         errors++; $display("FAIL ev1_read: cs=%b wn=%b addr=%0d required 1 1 0", avm_chipselect, avm_write_n, avm_address);
      end
      @(negedge clk);                           // T+2
      checks++;
      if (avm_chipselect !== 1'b0 || ev_valid !== 1'b0) begin
         errors++; $display("FAIL ev1_cap: cs=%b ev_valid=%b required 0 0", avm_chipselect, ev_valid);
      end
      @(negedge clk);                           // T+3
      checks++;
      if (ev_valid !== 1'b1 || ev_data[15:0] !== 16'h0005) begin
         errors++; $display("FAIL ev1_push: valid=%b data=%h required 1 0005", ev_valid, ev_data[15:0]);
      end
      checks++;
      if (!(avm_chipselect === 1'b1 && avm_write_n === 1'b0 && avm_address === 2'd2 && avm_writedata === 32'h000000FA)) begin
         errors++; $display("FAIL ev1_mask: cs=%b wn=%b addr=%0d wd=%h required 1 0 2 000000fa", avm_chipselect, avm_write_n, avm_address, avm_writedata);
      end
      @(negedge clk);                           // T+4
      checks++;
      if (armed !== 16'h00FA || avm_chipselect !== 1'b0) begin
         errors++; $display("FAIL ev1_idle: armed=%h cs=%b required 00fa 0", armed, avm_chipselect);
      end
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
      checks++;
      if (ev_valid !== 1'b0) begin
         errors++; $display("FAIL ev1_pop: ev_valid=%b required 0", ev_valid);
      end
   endtask

   task automatic test_hold_rearm;
      int w0;
      w0 = wr_count;
      repeat (6) @(negedge clk);
      checks++;
      if (ev_valid !== 1'b0 || wr_count !== w0) begin
         errors++; $display("FAIL hold_quiet: ev_valid=%b writes=%0d required 0 %0d", ev_valid, wr_count, w0);
      end
      rearm_valid = 1'b1; rearm_mask = 16'h0001;   // cycle t
      @(negedge clk);                              // t+1
      rearm_valid = 1'b0; rearm_mask = 16'h0000;
      @(negedge clk);                              // t+2
      checks++;
      if (!(avm_chipselect === 1'b1 && avm_write_n === 1'b0 && avm_writedata === 32'h000000FB)) begin
         errors++; $display("FAIL rearm_write: cs=%b wn=%b wd=%h required 1 0 000000fb", avm_chipselect, avm_write_n, avm_writedata);
      end
      repeat (4) @(negedge clk);                   // t+6
      checks++;
      if (ev_valid !== 1'b1 || ev_data[15:0] !== 16'h0001) begin
         errors++; $display("FAIL rearm_event: valid=%b data=%h required 1 0001", ev_valid, ev_data[15:0]);
      end
      checks++;
      if (avm_write_n !== 1'b0 || avm_writedata !== 32'h000000FA) begin
         errors++; $display("FAIL rearm_disarm: wn=%b wd=%h required 0 000000fa", avm_write_n, avm_writedata);
      end
      in_port = 16'h0000;
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
   endtask

   task automatic test_glitch;
      int w0;
      @(negedge clk);
      w0 = wr_count;
      in_port = 16'h0002;                          // cycle T
      @(negedge clk);                              // T+1
      in_port = 16'h0000;
      checks++;
      if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b1) begin
         errors++; $display("FAIL glitch_read: cs=%b wn=%b required 1 1", avm_chipselect, avm_write_n);
      end
      repeat (2) @(negedge clk);                   // T+3
      checks++;
      if (ev_valid !== 1'b0 || armed !== 16'h00FA) begin
         errors++; $display("FAIL glitch_nopush: valid=%b armed=%h required 0 00fa", ev_valid, armed);
      end
      checks++;
      if (avm_chipselect !== 1'b0 || wr_count !== w0) begin
         errors++; $display("FAIL glitch_idle: cs=%b writes=%0d required 0 %0d", avm_chipselect, wr_count, w0);
      end
   endtask

   task automatic test_overflow;
      logic [15:0] exp_q [4];
      exp_q[0] = 16'h0200; exp_q[1] = 16'h0400; exp_q[2] = 16'h0800; exp_q[3] = 16'h8000;
      rearm_valid = 1'b1; rearm_mask = 16'hFF00;
      @(negedge clk);
      rearm_valid = 1'b0; rearm_mask = 16'h0000;
      @(negedge clk);
      checks++;
      if (avm_write_n !== 1'b0 || avm_writedata !== 32'h0000FFFA) begin
         errors++; $display("FAIL ovf_arm: wn=%b wd=%h required 0 0000fffa", avm_write_n, avm_writedata);
      end
      @(negedge clk);
      for (int i = 0; i < DEPTH + 3; i++) begin
         in_port = 16'h0100 << i;
         repeat (4) @(negedge clk);
      end
      checks++;
      if (ovf_count !== 8'd3 || ev_valid !== 1'b1) begin
         errors++; $display("FAIL ovf_count: ovf=%0d valid=%b required 3 1", ovf_count, ev_valid);
      end
      checks++;
      if (ev_data[15:0] !== 16'h0100) begin
         errors++; $display("FAIL ovf_head: got %h required 0100", ev_data[15:0]);
      end
      in_port = 16'h8000;                          // cycle T
      repeat (2) @(negedge clk);                   // T+2 (capture cycle)
      ev_ready = 1'b1;
      @(negedge clk);                              // T+3
      ev_ready = 1'b0;
      checks++;
      if (ovf_count !== 8'd3) begin
         errors++; $display("FAIL full_pop_push: ovf=%0d required 3", ovf_count);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (ev_valid !== 1'b1 || ev_data[15:0] !== exp_q[k]) begin
            errors++; $display("FAIL drain_%0d: valid=%b data=%h required 1 %h", k, ev_valid, ev_data[15:0], exp_q[k]);
         end
`ifndef PIO_EVT_TIMESTAMP_EN
         checks++;
         if (ev_data[31:16] !== 16'h0000) begin
            errors++; $display("FAIL drain_ts_%0d: got %h required 0000", k, ev_data[31:16]);
         end
`endif
         ev_ready = 1'b1;
         @(negedge clk);
         ev_ready = 1'b0;
      end
      checks++;
      if (ev_valid !== 1'b0) begin
         errors++; $display("FAIL drain_empty: valid=%b required 0", ev_valid);
      end
      in_port = 16'h0000;
   endtask

   task automatic test_timestamp;
      logic [15:0] ts_a;
      logic [15:0] ts_b;
      repeat (2) @(negedge clk);
      in_port = 16'h0008;                          // T1
      repeat (10) @(negedge clk);
      in_port = 16'h0010;                          // T1+10
      repeat (4) @(negedge clk);
      checks++;
      if (ev_valid !== 1'b1 || ev_data[15:0] !== 16'h0008) begin
         errors++; $display("FAIL ts_first: valid=%b data=%h required 1 0008", ev_valid, ev_data[15:0]);
      end
      ts_a = ev_data[31:16];
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
      checks++;
      if (ev_valid !== 1'b1 || ev_data[15:0] !== 16'h0010) begin
         errors++; $display("FAIL ts_second: valid=%b data=%h required 1 0010", ev_valid, ev_data[15:0]);
      end
      ts_b = ev_data[31:16];
`ifdef PIO_EVT_TIMESTAMP_EN
      checks++;
      if (16'(ts_b - ts_a) !== 16'd10) begin
         errors++; $display("FAIL ts_delta: got %0d required 10", 16'(ts_b - ts_a));
      end
`else
      checks++;
      if (ts_a !== 16'h0000 || ts_b !== 16'h0000) begin
         errors++; $display("FAIL ts_zero: got %h %h required 0000 0000", ts_a, ts_b);
      end
`endif
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
      in_port = 16'h0000;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_event();
      test_hold_rearm();
      test_glitch();
      test_overflow();
      test_timestamp();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
